// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 schedule constants, sigma helpers and scheduler state type
package sha256_pkg;

   localparam int S0_ROT_A = 7;
   localparam int S0_ROT_B = 18;
   localparam int S0_SHR   = 3;
   localparam int S1_ROT_A = 17;
   localparam int S1_ROT_B = 19;
   localparam int S1_SHR   = 10;

   typedef enum logic {IDLE, RUN} sched_state_e;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sha256_sig0(input logic [31:0] x);
      return rotr32(x, S0_ROT_A) ^ rotr32(x, S0_ROT_B) ^ (x >> S0_SHR);
   endfunction

   function automatic logic [31:0] sha256_sig1(input logic [31:0] x);
      return rotr32(x, S1_ROT_A) ^ rotr32(x, S1_ROT_B) ^ (x >> S1_SHR);
   endfunction

endpackage

// File: rtl/sha256_w_next.sv
// rtl/sha256_w_next.sv - combinational next schedule word from a 16-word window
module sha256_w_next
   import sha256_pkg::*;
(
   input  logic [31:0] w0,
   input  logic [31:0] w1,
   input  logic [31:0] w9,
   input  logic [31:0] w14,
   output logic [31:0] w_new
);

   assign w_new = sha256_sig1(w14) + w9 + sha256_sig0(w1) + w0;

endmodule

// File: rtl/sha256_w_sched_stream.sv
// rtl/sha256_w_sched_stream.sv - streaming SHA-256 message schedule, one W[t] per cycle
module sha256_w_sched_stream
   import sha256_pkg::*;
#(
   parameter int NUM_ROUNDS = 64,
   parameter int IDX_W      = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [511:0]       in_block,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_word,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last
);

   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_ROUNDS - 2);

   sched_state_e       state, state_nxt;
   logic [31:0]        win [16];
   logic [IDX_W-1:0]   t;
   logic               last_q;
   logic [31:0]        w_new;
   logic               in_fire, out_fire;

   assign out_valid = (state == RUN);
   assign out_word  = win[0];
   assign out_idx   = t;
   assign out_last  = last_q;
   assign out_fire  = out_valid && out_ready;
   // The final word's handshake frees the window in the same cycle, so a waiting block loads with no bubble.
   assign in_ready  = !flush && ((state == IDLE) || (out_fire && out_last));
   assign in_fire   = in_valid && in_ready;

   sha256_w_next u_w_next (
      .w0    (win[0]),
      .w1    (win[1]),
      .w9    (win[9]),
      .w14   (win[14]),
      .w_new (w_new)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else if (in_fire) begin
         state_nxt = RUN;
      end else if (out_fire && out_last) begin
         state_nxt = IDLE;
      end
   end

   // Flush leaves the window contents alone; only the index and last flag restart.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         t      <= '0;
         last_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win[i] <= '0;
         end
      end else if (flush) begin
         t      <= '0;
         last_q <= 1'b0;
      end else if (in_fire) begin
         t      <= '0;
         last_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win[i] <= in_block[511 - 32*i -: 32];
         end
      end else if (out_fire) begin
         if (last_q) begin
            last_q <= 1'b0;
         end else begin
            for (int i = 0; i < 15; i++) begin
               win[i] <= win[i+1];
            end
            win[15] <= w_new;
            t       <= t + IDX_W'(1);
            last_q  <= (t == PENULT_IDX);
         end
      end
   end

endmodule

// File: tb/tb_sha256_w_sched_stream.sv
// tb/tb_sha256_w_sched_stream.sv - directed self-checking bench for sha256_w_sched_stream
module tb_sha256_w_sched_stream;

   localparam int NR = 64;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [511:0]  in_block = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_word;
   logic [5:0]    out_idx;
   logic          out_last;

   int total = 0;
   int bad   = 0;

   logic [31:0] got_w [$];
   logic [5:0]  got_idx [$];
   logic        got_last [$];
   logic [31:0] ref_abc [NR];
   logic [31:0] ref_b   [NR];
   logic [511:0] blk_abc;
   logic [511:0] blk_b;

   always #5 CLK = ~CLK;

   sha256_w_sched_stream #(.NUM_ROUNDS(NR), .IDX_W(6)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   task automatic build_ref(input logic [511:0] blk, input bit which);
      logic [31:0] w [NR];
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < NR; i++) begin
         s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < NR; i++) begin
         if (which) ref_b[i] = w[i]; else ref_abc[i] = w[i];
      end
   endtask

   // Entered and left at a negedge; checks W0 appears one cycle after the handshake.
   task automatic load_block(input logic [511:0] blk);
      in_valid = 1'b1;
      in_block = blk;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (in_ready) break;
         @(negedge CLK);
      end
      chk("load_ready", in_ready, 1);
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      chk("latency_valid", out_valid, 1);
      chk("latency_idx", out_idx, 0);
   endtask

   task automatic drain(input bit bp);
      int n;
      bit held;
      logic [31:0] hw;
      logic [5:0] hi;
      n = 0;
      held = 1'b0;
      hw = '0;
      hi = '0;
      got_w.delete();
      got_idx.delete();
      got_last.delete();
      for (int c = 0; c < 3000 && n < NR; c++) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (held) begin
            chk("stall_word", out_word, hw);
            chk("stall_idx", out_idx, hi);
         end
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               got_w.push_back(out_word);
               got_idx.push_back(out_idx);
               got_last.push_back(out_last);
               n++;
            end else begin
               held = 1'b1;
               hw = out_word;
               hi = out_idx;
            end
         end
         @(negedge CLK);
      end
      out_ready = 1'b1;
      chk("drain_count", n, NR);
      #1;
      chk("idle_after_block", out_valid, 0);
   endtask

   task automatic compare_stream(input bit which, input int off);
      logic [31:0] e;
      for (int i = 0; i < NR; i++) begin
         e = which ? ref_b[i] : ref_abc[i];
         if (off + i < got_w.size()) begin
            chk($sformatf("w[%0d]", i), got_w[off+i], e);
            chk($sformatf("idx[%0d]", i), got_idx[off+i], i);
            chk($sformatf("last[%0d]", i), got_last[off+i], (i == NR-1));
         end else begin
            chk("stream_short", got_w.size(), off + NR);
         end
      end
   endtask

   task automatic run_to_idx(input int target);
      for (int n = 0; n < 200; n++) begin
         out_ready = 1'b1;
         #1;
         if (out_valid && out_idx == 6'(target)) break;
         @(negedge CLK);
      end
      chk("reach_idx", out_idx, target);
   endtask

   initial begin
      blk_abc = {32'h61626380, 448'b0, 32'h00000018};
      for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'h9e3779b9 * (i + 1) ^ 32'h0f0f0000;
      build_ref(blk_abc, 1'b0);
      build_ref(blk_b, 1'b1);

      // reset state
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_word", out_word, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      @(negedge CLK);

      // abc, no backpressure, with known schedule words
      load_block(blk_abc);
      drain(1'b0);
      compare_stream(1'b0, 0);
      if (got_w.size() == NR) begin
         chk("abc_w0", got_w[0], 32'h61626380);
         chk("abc_w15", got_w[15], 32'h00000018);
         chk("abc_w16", got_w[16], 32'h61626380);
         chk("abc_w17", got_w[17], 32'h000F0000);
         chk("abc_w18", got_w[18], 32'h7DA86405);
         chk("abc_w63", got_w[63], 32'h12B1EDEB);
      end else begin
         chk("abc_size", got_w.size(), NR);
      end
      @(negedge CLK);

      // abc under random backpressure
      load_block(blk_abc);
      drain(1'b1);
      compare_stream(1'b0, 0);
      @(negedge CLK);

      // back to back: A then B with in_valid held
      begin
         bit b_acc;
         int gaps;
         got_w.delete();
         got_idx.delete();
         got_last.delete();
         in_valid = 1'b1;
         in_block = blk_abc;
         #1;
         chk("b2b_a_ready", in_ready, 1);
         @(negedge CLK);
         in_block = blk_b;
         b_acc = 1'b0;
         gaps = 0;
         for (int c = 0; c < 400 && got_w.size() < 2*NR; c++) begin
            in_valid = !b_acc;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
               got_w.push_back(out_word);
               got_idx.push_back(out_idx);
               got_last.push_back(out_last);
            end else begin
               gaps++;
            end
            if (in_valid && in_ready) b_acc = 1'b1;
            @(negedge CLK);
         end
         in_valid = 1'b0;
         chk("b2b_gaps", gaps, 0);
         chk("b2b_count", got_w.size(), 2*NR);
         compare_stream(1'b0, 0);
         compare_stream(1'b1, NR);
         #1;
         chk("b2b_idle_after", out_valid, 0);
         @(negedge CLK);
      end

      // flush at t=20 with a block offered
      load_block(blk_abc);
      run_to_idx(20);
      flush = 1'b1;
      in_valid = 1'b1;
      in_block = blk_b;
      #1;
      chk("flush_in_ready", in_ready, 0);
      @(negedge CLK);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_idx", out_idx, 0);
      @(negedge CLK);
      #1;
      chk("flush_not_accepted", out_valid, 0);
      @(negedge CLK);
      load_block(blk_b);
      drain(1'b0);
      compare_stream(1'b1, 0);
      @(negedge CLK);

      // reset mid-block at t=30
      load_block(blk_abc);
      run_to_idx(30);
      RST = 1'b1;
      #1;
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_word", out_word, 0);
      chk("mrst_out_idx", out_idx, 0);
      chk("mrst_out_last", out_last, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("mrst_quiet0", out_valid, 0);
      @(negedge CLK);
      #1;
      chk("mrst_quiet1", out_valid, 0);
      @(negedge CLK);
      load_block(blk_abc);
      drain(1'b0);
      compare_stream(1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
